// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and write-back, and drives datapath selects and strobes.
module multicycle_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic [1:0]  pc_source,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        mem_to_reg,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        illegal_op,
    output logic [3:0]  state,
    output logic [31:0] instr_count
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam int NUM_STATES = 10;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        JUMP    = 4'd9
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] instr_count_reg;
    logic        retire;

    logic is_rtype;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_j;
    logic op_known;

    assign is_rtype = (opcode == OP_RTYPE);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_j     = (opcode == OP_J);
    assign op_known = is_rtype | is_lw | is_sw | is_beq | is_j;

    // One-hot view of the state register; codes 10-15 light no bit, so they
    // produce no outputs and fall through to FETCH in the next-state logic.
    logic [NUM_STATES-1:0] in_state;

    generate
        for (genvar gi = 0; gi < NUM_STATES; gi++) begin : g_state_hot
            assign in_state[gi] = (state_reg == 4'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= FETCH;
            instr_count_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            if (retire) begin
                instr_count_reg <= instr_count_reg + 32'd1;
            end
        end
    end

    always_comb begin
        state_next = FETCH;
        retire     = 1'b0;
        case (state_reg)
            FETCH: begin
                state_next = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                if (is_rtype) begin
                    state_next = EXECUTE;
                end else if (is_lw || is_sw) begin
                    state_next = MEMADR;
                end else if (is_beq) begin
                    state_next = BRANCH;
                end else if (is_j) begin
                    state_next = JUMP;
                end else begin
                    state_next = FETCH;
                end
            end
            MEMADR: begin
                if (is_lw) begin
                    state_next = MEMRD;
                end else if (is_sw) begin
                    state_next = MEMWR;
                end else begin
                    state_next = FETCH;
                end
            end
            MEMRD: begin
                state_next = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                state_next = FETCH;
                retire     = 1'b1;
            end
            MEMWR: begin
                state_next = mem_ready ? FETCH : MEMWR;
                retire     = mem_ready;
            end
            EXECUTE: begin
                state_next = ALUWB;
            end
            ALUWB, BRANCH, JUMP: begin
                state_next = FETCH;
                retire     = 1'b1;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // Outputs are a pure decode of the state, held at zero while reset is
    // asserted so nothing strobes even though the register already sits in FETCH.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        illegal_op    = 1'b0;
        if (!rst) begin
            pc_write      = (in_state[FETCH] & mem_ready) | in_state[JUMP];
            ir_write      = in_state[FETCH] & mem_ready;
            pc_write_cond = in_state[BRANCH];
            pc_source     = {in_state[JUMP], in_state[BRANCH]};
            i_or_d        = in_state[MEMRD] | in_state[MEMWR];
            mem_read      = in_state[FETCH] | in_state[MEMRD];
            mem_write     = in_state[MEMWR];
            mem_to_reg    = in_state[MEMWB];
            reg_dst       = in_state[ALUWB];
            reg_write     = in_state[MEMWB] | in_state[ALUWB];
            alu_src_a     = in_state[MEMADR] | in_state[EXECUTE] | in_state[BRANCH];
            alu_src_b     = {in_state[DECODE] | in_state[MEMADR],
                             in_state[FETCH] | in_state[DECODE]};
            alu_op        = {in_state[EXECUTE], in_state[BRANCH]};
            illegal_op    = in_state[DECODE] & ~op_known;
        end
    end

    assign state       = state_reg;
    assign instr_count = instr_count_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomised bench for multicycle_control: each instruction's expected state
// path and per-state control word come from a table-level reference model.
module tb_multicycle_control;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        pc_write;
    logic        pc_write_cond;
    logic [1:0]  pc_source;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        mem_to_reg;
    logic        reg_dst;
    logic        reg_write;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic        illegal_op;
    logic [3:0]  state;
    logic [31:0] instr_count;

    int total = 0;
    int bad   = 0;
    int exp_count = 0;
    int n_instr = 0;

    logic [16:0] dut_ctrl;
    assign dut_ctrl = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                       alu_op, illegal_op};

    multicycle_control dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .illegal_op    (illegal_op),
        .state         (state),
        .instr_count   (instr_count)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J);
    endfunction

    // Control word listed per state, in dut_ctrl field order.
    function automatic logic [16:0] model_ctrl(input int s, input logic mr, input logic [5:0] op);
        logic pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa, ill;
        logic [1:0] psrc, asb, aop;
        {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa, ill} = '0;
        psrc = 2'b00; asb = 2'b00; aop = 2'b00;
        case (s)
            0: begin mrd = 1'b1; asb = 2'b01; irw = mr; pw = mr; end
            1: begin asb = 2'b11; ill = !is_legal(op); end
            2: begin asa = 1'b1; asb = 2'b10; end
            3: begin mrd = 1'b1; iod = 1'b1; end
            4: begin rw = 1'b1; m2r = 1'b1; end
            5: begin mwr = 1'b1; iod = 1'b1; end
            6: begin asa = 1'b1; aop = 2'b10; end
            7: begin rd = 1'b1; rw = 1'b1; end
            8: begin asa = 1'b1; aop = 2'b01; pwc = 1'b1; psrc = 2'b01; end
            9: begin pw = 1'b1; psrc = 2'b10; end
            default: ;
        endcase
        return {pw, pwc, psrc, iod, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop, ill};
    endfunction

    // hold < 0: random mem_ready; hold >= 0: ready except `hold` low cycles in MEMRD/MEMWR.
    task automatic run_instr(input logic [5:0] op, input int hold);
        int  seq[$];
        bit  ret;
        bit  has_mem;
        int  idx;
        int  cyc;
        int  stalls;
        logic mr;
        ret = 1'b1;
        case (op)
            OP_LW:    seq = '{0, 1, 2, 3, 4};
            OP_SW:    seq = '{0, 1, 2, 5};
            OP_RTYPE: seq = '{0, 1, 6, 7};
            OP_BEQ:   seq = '{0, 1, 8};
            OP_J:     seq = '{0, 1, 9};
            default: begin seq = '{0, 1}; ret = 1'b0; end
        endcase
        has_mem = (op == OP_LW) || (op == OP_SW);
        idx = 0; cyc = 0; stalls = 0;
        while (idx < seq.size()) begin
            @(negedge clk);
            if (hold < 0) begin
                mr = ($urandom_range(99) < 70);
            end else if ((seq[idx] == 3 || seq[idx] == 5) && stalls < hold) begin
                mr = 1'b0;
                stalls++;
            end else begin
                mr = 1'b1;
            end
            opcode    = op;
            mem_ready = mr;
            #1;
            check_value("state", 32'(state), 32'(seq[idx]));
            check_value("ctrl", 32'(dut_ctrl), 32'(model_ctrl(seq[idx], mr, op)));
            check_value("count", instr_count, 32'(exp_count));
            cyc++;
            if (!((seq[idx] == 0 || seq[idx] == 3 || seq[idx] == 5) && !mr)) idx++;
        end
        if (hold >= 0) check_value("latency", 32'(cyc), 32'(seq.size() + (has_mem ? hold : 0)));
        if (ret) exp_count++;
        n_instr++;
        $display("instr %0d op=%b cycles=%0d expected_count=%0d", n_instr, op, cyc, exp_count);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] op;
        rst = 1'b1; opcode = OP_LW; mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check_value("rst_state", 32'(state), 32'd0);
        check_value("rst_ctrl", 32'(dut_ctrl), 32'd0);
        check_value("rst_count", instr_count, 32'd0);
        @(negedge clk);
        mem_ready = 1'b0;
        rst = 1'b0;
        #1;
        check_value("post_rst_ctrl", 32'(dut_ctrl), 32'(model_ctrl(0, 1'b0, OP_LW)));

        // Directed scenarios
        run_instr(OP_LW, 0);
        run_instr(OP_RTYPE, 0);
        run_instr(OP_SW, 3);
        run_instr(OP_BEQ, 0);
        run_instr(OP_J, 0);
        run_instr(6'b111111, 0);
        run_instr(OP_LW, 2);

        // Asynchronous reset while sitting in MEMRD
        @(negedge clk); opcode = OP_LW; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); mem_ready = 1'b0;
        #1;
        check_value("pre_abort_state", 32'(state), 32'd3);
        #1 rst = 1'b1;
        #1;
        check_value("abort_state", 32'(state), 32'd0);
        check_value("abort_ctrl", 32'(dut_ctrl), 32'd0);
        check_value("abort_count", instr_count, 32'd0);
        exp_count = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_value("resume_ctrl", 32'(dut_ctrl), 32'(model_ctrl(0, 1'b0, OP_LW)));
        $display("async reset in MEMRD, instruction aborted");

        // Randomised instruction stream
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(5))
                0: op = OP_RTYPE;
                1: op = OP_LW;
                2: op = OP_SW;
                3: op = OP_BEQ;
                4: op = OP_J;
                default: begin
                    op = 6'($urandom);
                    while (is_legal(op)) op = 6'($urandom);
                end
            endcase
            run_instr(op, ($urandom_range(3) == 0) ? int'($urandom_range(4)) : -1);
        end

        @(negedge clk); #1;
        check_value("final_count", instr_count, 32'(exp_count));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
